// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the single-bus transfer sequencer.
//   - opcode encodings for the command port
//   - FSM state encoding
//   - helpers telling which register indices an opcode uses
package bus_xfer_pkg;

    localparam logic [1:0] OP_MOV   = 2'b00;
    localparam logic [1:0] OP_SWAP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        FIN  = 3'd4
    } state_t;

    // LOAD takes its data from outside, so it has no source register
    function automatic logic uses_src(input logic [1:0] op);
        return op != OP_LOAD;
    endfunction

    // STORE sends its data outside, so it has no destination register
    function automatic logic uses_dst(input logic [1:0] op);
        return op != OP_STORE;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Binary-to-one-hot decoder with enable.
//   en  : when 0 the output is all zeros
//   sel : binary index
//   dec : one-hot output, zero when disabled or sel is out of range
module onehot_dec #(
    parameter int SEL_W    = 2,
    parameter int NUM_REGS = 4
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] dec
);

    always_comb begin
        dec = '0;
        if (en && (int'(sel) < NUM_REGS))
            dec[sel] = 1'b1;
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Transfer sequencer for a register array sharing one data bus.
// Runs MOV / SWAP / LOAD / STORE commands by emitting registered one-hot
// load strobes (r_in) and drive enables (r_out), at most one driver and
// one sink per cycle. SWAP goes through the reserved temp register.
//   clk, reset       : clock, synchronous active-high reset
//   start, op        : command valid and opcode (sampled when not busy)
//   src_sel, dst_sel : register indices
//   r_in, r_out      : register load strobes / bus drive enables
//   ext_out, ext_in  : external source drives bus / external sink captures
//   busy, done, err  : in progress, completion pulse, rejected (with done)
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int TMP_IDX  = 3,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [SEL_W-1:0]    src_sel,
    input  logic [SEL_W-1:0]    dst_sel,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic                ext_out,
    output logic                ext_in,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [SEL_W-1:0] TMP_SEL = SEL_W'(TMP_IDX);

    state_t           state;
    logic [1:0]       op_q;
    logic [SEL_W-1:0] src_q, dst_q;

    function automatic logic idx_ok(input logic [SEL_W-1:0] idx);
        return (int'(idx) < NUM_REGS) && (idx != TMP_SEL);
    endfunction

    logic accept, cmd_ok;
    assign accept = ((state == IDLE) || (state == FIN)) && start;
    assign cmd_ok = (!uses_src(op) || idx_ok(src_sel)) &&
                    (!uses_dst(op) || idx_ok(dst_sel));

    // Strobes for the cycle after the coming edge; decoded here and then
    // registered so every output comes straight from a flop.
    logic             nin_en, nout_en, nxt_ext_out, nxt_ext_in;
    logic [SEL_W-1:0] nin_sel, nout_sel;

    always_comb begin
        nin_en      = 1'b0;
        nin_sel     = '0;
        nout_en     = 1'b0;
        nout_sel    = '0;
        nxt_ext_out = 1'b0;
        nxt_ext_in  = 1'b0;
        if (accept && cmd_ok) begin
            case (op)
                OP_MOV: begin
                    nout_en = 1'b1; nout_sel = src_sel;
                    nin_en  = 1'b1; nin_sel  = dst_sel;
                end
                OP_SWAP: begin
                    nout_en = 1'b1; nout_sel = src_sel;
                    nin_en  = 1'b1; nin_sel  = TMP_SEL;
                end
                OP_LOAD: begin
                    nxt_ext_out = 1'b1;
                    nin_en = 1'b1; nin_sel = dst_sel;
                end
                default: begin
                    nout_en = 1'b1; nout_sel = src_sel;
                    nxt_ext_in = 1'b1;
                end
            endcase
        end else if ((state == S1) && (op_q == OP_SWAP)) begin
            nout_en = 1'b1; nout_sel = dst_q;
            nin_en  = 1'b1; nin_sel  = src_q;
        end else if (state == S2) begin
            nout_en = 1'b1; nout_sel = TMP_SEL;
            nin_en  = 1'b1; nin_sel  = dst_q;
        end
    end

    logic [NUM_REGS-1:0] nxt_r_in, nxt_r_out;

    onehot_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_in_dec (
        .en(nin_en), .sel(nin_sel), .dec(nxt_r_in)
    );

    onehot_dec #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_out_dec (
        .en(nout_en), .sel(nout_sel), .dec(nxt_r_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_MOV;
            src_q   <= '0;
            dst_q   <= '0;
            r_in    <= '0;
            r_out   <= '0;
            ext_out <= 1'b0;
            ext_in  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_in    <= nxt_r_in;
            r_out   <= nxt_r_out;
            ext_out <= nxt_ext_out;
            ext_in  <= nxt_ext_in;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        op_q  <= op;
                        src_q <= src_sel;
                        dst_q <= dst_sel;
                        if (cmd_ok) begin
                            state <= S1;
                            busy  <= 1'b1;
                        end else begin
                            // rejected: straight to completion, no strobes
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                S1: begin
                    if (op_q == OP_SWAP) begin
                        state <= S2;
                    end else begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S2: state <= S3;
                S3: begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [1:0] op, src_sel, dst_sel;
    logic [3:0] r_in, r_out;
    logic       ext_out, ext_in, busy, done, err;
    logic [7:0] ext_data = 8'h00;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.NUM_REGS(4), .TMP_IDX(3), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_sel(src_sel), .dst_sel(dst_sel),
        .r_in(r_in), .r_out(r_out), .ext_out(ext_out), .ext_in(ext_in),
        .busy(busy), .done(done), .err(err)
    );

    // Bus environment: registers and external sink react to the strobes.
    logic [7:0] regs [4] = '{default: 8'h00};
    logic [7:0] captured = 8'h00;
    logic [7:0] bus;
    always @(posedge clk) begin
        bus = ext_out ? ext_data : 8'h00;
        for (int i = 0; i < 4; i++) if (r_out[i]) bus = regs[i];
        for (int i = 0; i < 4; i++) if (r_in[i]) regs[i] <= bus;
        if (ext_in) captured <= bus;
    end

    typedef struct packed {
        logic [3:0] r_in;
        logic [3:0] r_out;
        logic       ext_out, ext_in, busy, done, err;
    } obs_t;

    obs_t  exp_q [$];
    string name_q [$];
    int    n_chk = 0, n_fail = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic obs_t row(input logic [3:0] ri, input logic [3:0] ro,
                                 input logic xo, input logic xi,
                                 input logic b, input logic d, input logic e);
        return '{r_in: ri, r_out: ro, ext_out: xo, ext_in: xi, busy: b, done: d, err: e};
    endfunction

    task automatic push(input string nm, input obs_t o);
        exp_q.push_back(o);
        name_q.push_back(nm);
    endtask

    // Any cycle with a nonzero output is a presented response to be matched.
    task automatic monitor();
        obs_t o, e;
        string nm;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                o = {r_in, r_out, ext_out, ext_in, busy, done, err};
                chk("one_driver", 32'($countones(r_out) + int'(ext_out) <= 1), 32'd1);
                chk("one_sink", 32'($countones(r_in) + int'(ext_in) <= 1), 32'd1);
                chk("no_strobe_idle", 32'(!busy && ((|r_in) || (|r_out) || ext_out || ext_in)), 32'd0);
                if (o != '0) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0h expected none", o);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        chk(nm, 32'(o), 32'(e));
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d);
        @(negedge clk);
        start = 1'b1; op = o; src_sel = s; dst_sel = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        fork monitor(); join_none

        // reset overrides a valid start
        reset = 1'b1; start = 1'b1; op = 2'b00; src_sel = 2'd0; dst_sel = 2'd2;
        idle(2);
        chk("reset_outputs", {r_in, r_out, ext_out, ext_in, busy, done, err}, '0);
        reset = 1'b0; start = 1'b0;
        idle(1);
        chk("post_reset_idle", {r_in, r_out, ext_out, ext_in, busy, done, err}, '0);
        mon_en = 1'b1;

        // R0 = 1, R1 = 0 via LOAD
        ext_data = 8'h01;
        push("load_r0_s1", row(4'b0001, 4'b0000, 1, 0, 1, 0, 0));
        push("load_r0_fin", row(4'b0000, 4'b0000, 0, 0, 0, 1, 0));
        issue(2'b10, 2'd0, 2'd0); idle(3);
        ext_data = 8'h00;
        push("load_r1_s1", row(4'b0010, 4'b0000, 1, 0, 1, 0, 0));
        push("load_r1_fin", row(4'b0000, 4'b0000, 0, 0, 0, 1, 0));
        issue(2'b10, 2'd0, 2'd1); idle(3);

        // MOV R0 -> R2
        push("mov_s1", row(4'b0100, 4'b0001, 0, 0, 1, 0, 0));
        push("mov_fin", row(4'b0000, 4'b0000, 0, 0, 0, 1, 0));
        issue(2'b00, 2'd0, 2'd2); idle(3);
        chk("mov_r2", 32'(regs[2]), 32'h01);

        // SWAP R0 <-> R1
        push("swap01_s1", row(4'b1000, 4'b0001, 0, 0, 1, 0, 0));
        push("swap01_s2", row(4'b0001, 4'b0010, 0, 0, 1, 0, 0));
        push("swap01_s3", row(4'b0010, 4'b1000, 0, 0, 1, 0, 0));
        push("swap01_fin", row(4'b0000, 4'b0000, 0, 0, 0, 1, 0));
        issue(2'b01, 2'd0, 2'd1); idle(5);
        chk("swap_r0", 32'(regs[0]), 32'h00);
        chk("swap_r1", 32'(regs[1]), 32'h01);

        // rejected commands touching the temp register
        push("err_mov_src", row(4'b0000, 4'b0000, 0, 0, 0, 1, 1));
        issue(2'b00, 2'd3, 2'd0); idle(2);
        push("err_load_dst", row(4'b0000, 4'b0000, 0, 0, 0, 1, 1));
        issue(2'b10, 2'd0, 2'd3); idle(2);

        // back-to-back LOAD R1 then STORE R1, start held through FIN
        ext_data = 8'h5A;
        push("b2b_load_s1", row(4'b0010, 4'b0000, 1, 0, 1, 0, 0));
        push("b2b_load_fin", row(4'b0000, 4'b0000, 0, 0, 0, 1, 0));
        push("b2b_store_s1", row(4'b0000, 4'b0010, 0, 1, 1, 0, 0));
        push("b2b_store_fin", row(4'b0000, 4'b0000, 0, 0, 0, 1, 0));
        @(negedge clk); start = 1'b1; op = 2'b10; src_sel = 2'd0; dst_sel = 2'd1;
        @(negedge clk); op = 2'b11; src_sel = 2'd1; dst_sel = 2'd0;
        @(negedge clk);
        @(negedge clk); start = 1'b0;
        chk("b2b_no_bubble", {r_out, ext_in}, {4'b0010, 1'b1});
        idle(3);
        chk("store_captured", 32'(captured), 32'h5A);
        ext_data = 8'h00;

        // SWAP R2 <-> R0 with a start pulse in S2 that must be dropped
        push("swap20_s1", row(4'b1000, 4'b0100, 0, 0, 1, 0, 0));
        push("swap20_s2", row(4'b0100, 4'b0001, 0, 0, 1, 0, 0));
        push("swap20_s3", row(4'b0001, 4'b1000, 0, 0, 1, 0, 0));
        push("swap20_fin", row(4'b0000, 4'b0000, 0, 0, 0, 1, 0));
        issue(2'b01, 2'd2, 2'd0);
        @(negedge clk); start = 1'b1; op = 2'b00; src_sel = 2'd1; dst_sel = 2'd2;
        @(negedge clk); start = 1'b0;
        idle(5);
        chk("swap_r2", 32'(regs[2]), 32'h00);
        chk("swap_r0b", 32'(regs[0]), 32'h01);

        // reset in SWAP S2 aborts without a done pulse
        push("abort_s1", row(4'b1000, 4'b0001, 0, 0, 1, 0, 0));
        push("abort_s2", row(4'b0001, 4'b0010, 0, 0, 1, 0, 0));
        issue(2'b01, 2'd0, 2'd1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("abort_clear", {r_in, r_out, ext_out, ext_in, busy, done, err}, '0);
        idle(4);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Sequencer for the shared single-bus register array.
- Each register in the array has a load strobe (r_in) and a tristate drive enable (r_out).
- Accepts one transfer command at a time (MOV, SWAP, LOAD, STORE) and emits registered one-hot r_in/r_out strobes cycle by cycle.
- Guarantees that at most one bus driver is enabled in any cycle; SWAP uses a reserved temp register in the array.

Parameters:
- NUM_REGS, 4, number of registers on the bus (minimum 3).
- TMP_IDX, 3, index of the temp register used by SWAP; reserved, not addressable by commands.
- SEL_W, 2, width of the select fields; equals clog2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command valid; sampled only while busy=0.
- op  input  2  command: 00 MOV src->dst, 01 SWAP src<->dst, 10 LOAD ext->dst, 11 STORE src->ext.
- src_sel  input  SEL_W  source register index.
- dst_sel  input  SEL_W  destination register index.
- r_in  output  NUM_REGS  one-hot (or zero) register load strobes.
- r_out  output  NUM_REGS  one-hot (or zero) register tristate enables.
- ext_out  output  1  external driver enables its data onto the bus (LOAD).
- ext_in  output  1  external sink captures the bus (STORE).
- busy  output  1  a command is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done: command rejected.

Behaviour:
- Reset (synchronous, reset=1 at an edge): state IDLE; r_in, r_out, ext_out, ext_in, busy, done, err all 0. Reset overrides start. Reset mid-command aborts it; all strobes are 0 from the following cycle.
- All outputs are registered.
- States: IDLE, S1, S2, S3, FIN.
- Accept: in IDLE or FIN, start=1 latches op, src_sel and dst_sel, then:
  - Validation: if a used index is >= NUM_REGS or == TMP_IDX, go to FIN with err=1 and issue no strobes. MOV checks src and dst; SWAP checks src and dst; LOAD checks dst only; STORE checks src only.
  - Valid command: go to S1; busy=1 from that cycle until FIN.
- Strobes per state:
  - MOV: S1 sets r_out[src]=1 and r_in[dst]=1, then FIN.
  - LOAD: S1 sets ext_out=1 and r_in[dst]=1, then FIN.
  - STORE: S1 sets r_out[src]=1 and ext_in=1, then FIN.
  - SWAP: S1 moves src->tmp, S2 moves dst->src, S3 moves tmp->dst, then FIN.
- Latency from the start edge: MOV/LOAD/STORE take 1 strobe cycle, with done on cycle 2. SWAP takes 3 strobe cycles, with done on cycle 4.
- FIN: done=1 for exactly one cycle; busy=0; err valid only while done=1. start in FIN is accepted (back-to-back commands, no bubble). Without start, next state is IDLE.
- start while busy=1 (S1–S3) is ignored; it is not queued.
- src==dst is legal:
  - MOV self-reloads the register.
  - SWAP runs all 3 steps and leaves the value unchanged.
- Invariants, every cycle:
  - popcount(r_out) + ext_out <= 1.
  - popcount(r_in) + ext_in <= 1.
  - No strobe is active in IDLE or FIN.
- The target register captures the bus at the clock edge that ends its strobe cycle.

Decomposition:
- Shared package bus_xfer_pkg holds:
  - opcode constants OP_MOV, OP_SWAP, OP_LOAD, OP_STORE;
  - the state encoding for IDLE, S1, S2, S3, FIN.
- One sub-module: onehot_dec. Parameterised SEL_W to NUM_REGS decoder with an enable input; output is zero when disabled.
- Two instances of onehot_dec, one driving r_in and one driving r_out.

Test Plan:
- Reset: reset=1 with start=1 for 2 cycles -> all outputs 0; release reset -> state IDLE, busy=0.
- MOV: op=00, src=0, dst=2 -> cycle 1: r_out=0001, r_in=0100; cycle 2: done=1, err=0, strobes 0000. A register model shows R2 equals the old R0.
- SWAP: R0=1, R1=0; op=01, src=0, dst=1 -> r_out/r_in per cycle are 0001/1000, then 0010/0001, then 1000/0010; done on cycle 4. Result R0=0, R1=1.
- Error: op=00, src=3 (== TMP_IDX) -> cycle 1: done=1, err=1; no strobe ever asserted. Repeat with op=10, dst=3 -> same result.
- Back-to-back: LOAD dst=1 with start held high into FIN, followed by STORE src=1 -> STORE strobe cycle (r_out=0010, ext_in=1) directly follows the LOAD done cycle. start pulsed during SWAP S2 is ignored.
- Abort: reset=1 during SWAP S2 -> next cycle all strobes 0 and busy=0, no done pulse. Bus-contention invariant is checked by assertion throughout all tests.
